// File: rtl/hb2_decryption.sv
// Iterative Hummingbird-2 single-word decryptor: one inverse WD16 round per clock,
// 16 rounds per word, valid/ready handshakes on input and output.
module hb2_decryption (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  ct,
    input  logic [127:0] key,
    input  logic [15:0]  r1,
    input  logic [15:0]  r2,
    input  logic [15:0]  r3,
    input  logic [15:0]  r4,
    input  logic [15:0]  r5,
    input  logic [15:0]  r6,
    input  logic [15:0]  r7,
    input  logic [15:0]  r8,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  pt,
    output logic [15:0]  r1_o,
    output logic [15:0]  r2_o,
    output logic [15:0]  r3_o,
    output logic [15:0]  r4_o,
    output logic [15:0]  r5_o,
    output logic [15:0]  r6_o,
    output logic [15:0]  r7_o,
    output logic [15:0]  r8_o
);

    // Inverse nibble S-boxes; SINV1 serves the least significant nibble.
    localparam logic [3:0] SINV1 [16] = '{4'hB, 4'h5, 4'h4, 4'hF, 4'hC, 4'h6, 4'h9, 4'h0,
                                          4'hD, 4'h3, 4'hE, 4'h8, 4'h1, 4'hA, 4'h2, 4'h7};
    localparam logic [3:0] SINV2 [16] = '{4'h9, 4'h2, 4'hF, 4'h8, 4'h0, 4'hC, 4'h3, 4'h6,
                                          4'h4, 4'hD, 4'h1, 4'hE, 4'h7, 4'hB, 4'hA, 4'h5};
    localparam logic [3:0] SINV3 [16] = '{4'hC, 4'h3, 4'h0, 4'hA, 4'hB, 4'h4, 4'h5, 4'hF,
                                          4'h9, 4'hE, 4'h6, 4'hD, 4'h2, 4'h7, 4'h8, 4'h1};
    localparam logic [3:0] SINV4 [16] = '{4'hA, 4'h7, 4'h6, 4'h9, 4'h1, 4'h2, 4'hC, 4'h5,
                                          4'h3, 4'h4, 4'h8, 4'hF, 4'hD, 4'hE, 4'hB, 4'h0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [127:0] r_key;
    logic [15:0]  r_r [8];
    logic [15:0]  r_v;
    logic [15:0]  r_t3;
    logic [15:0]  r_t2;
    logic [15:0]  r_t1;
    logic [1:0]   r_stage;
    logic [1:0]   r_round;
    logic [15:0]  r_pt;
    logic [15:0]  r_o [8];

    logic [15:0]  w_lin;
    logic [15:0]  w_f;
    logic [2:0]   w_kidx;
    logic [15:0]  w_rk;
    logic         w_mask_en;
    logic [15:0]  w_x;
    logic [15:0]  w_sub;
    logic [15:0]  w_n1;
    logic [15:0]  w_n2;
    logic [15:0]  w_n3;
    logic [15:0]  w_n4;

    // Round j of a stage consumes key word (3-j) of its group; even stages use K5..K8.
    always_comb begin
        w_lin = r_v ^ {r_v[13:0], r_v[15:14]} ^ {r_v[11:0], r_v[15:12]}
                    ^ {r_v[3:0], r_v[15:4]} ^ {r_v[1:0], r_v[15:2]};
        w_f = {SINV4[w_lin[15:12]], SINV3[w_lin[11:8]], SINV2[w_lin[7:4]], SINV1[w_lin[3:0]]};
        w_kidx = {~r_stage[0], ~r_round};
        w_rk = r_key[{3'd7 - w_kidx, 4'd0} +: 16];
        w_mask_en = r_stage[0] ^ r_stage[1];
        w_x = w_f ^ w_rk ^ (w_mask_en ? r_r[{1'b1, ~r_round}] : '0);
        w_sub = w_x - r_r[{1'b0, ~r_stage}];
        w_n1 = r_r[0] + r_t3;
        w_n2 = r_r[1] + r_t1;
        w_n3 = r_r[2] + r_t2;
        w_n4 = r_r[3] + r_r[0] + r_t3 + r_t1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_key       <= '0;
            r_v         <= '0;
            r_t3        <= '0;
            r_t2        <= '0;
            r_t1        <= '0;
            r_stage     <= '0;
            r_round     <= '0;
            r_pt        <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_r[i] <= '0;
                r_o[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_key      <= key;
                        r_r[0]     <= r1;
                        r_r[1]     <= r2;
                        r_r[2]     <= r3;
                        r_r[3]     <= r4;
                        r_r[4]     <= r5;
                        r_r[5]     <= r6;
                        r_r[6]     <= r7;
                        r_r[7]     <= r8;
                        r_v        <= ct - r1;
                        r_stage    <= '0;
                        r_round    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_round <= r_round + 2'd1;
                    if (r_round == 2'd3) begin
                        r_v     <= w_sub;
                        r_stage <= r_stage + 2'd1;
                        case (r_stage)
                            2'd0: r_t3 <= w_sub;
                            2'd1: r_t2 <= w_sub;
                            2'd2: r_t1 <= w_sub;
                            default: begin
                                r_pt        <= w_sub;
                                r_o[0]      <= w_n1;
                                r_o[1]      <= w_n2;
                                r_o[2]      <= w_n3;
                                r_o[3]      <= w_n4;
                                r_o[4]      <= r_r[4] ^ w_n1;
                                r_o[5]      <= r_r[5] ^ w_n2;
                                r_o[6]      <= r_r[6] ^ w_n3;
                                r_o[7]      <= r_r[7] ^ w_n4;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end
                        endcase
                    end else begin
                        r_v <= w_x;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pt        = r_pt;
    assign r1_o      = r_o[0];
    assign r2_o      = r_o[1];
    assign r3_o      = r_o[2];
    assign r4_o      = r_o[3];
    assign r5_o      = r_o[4];
    assign r6_o      = r_o[5];
    assign r7_o      = r_o[6];
    assign r8_o      = r_o[7];

endmodule

// File: tb/tb_hb2_decryption.sv
// Directed bench for hb2_decryption: ciphertexts come from a forward Hummingbird-2
// encryptor model, so every decrypted word and state is a round-trip check.
module tb_hb2_decryption;

    localparam logic [3:0] SB1 [16] = '{4'd7, 4'd12, 4'd14, 4'd9, 4'd2, 4'd1, 4'd5, 4'd15,
                                        4'd11, 4'd6, 4'd13, 4'd0, 4'd4, 4'd8, 4'd10, 4'd3};
    localparam logic [3:0] SB2 [16] = '{4'd4, 4'd10, 4'd1, 4'd6, 4'd8, 4'd15, 4'd7, 4'd12,
                                        4'd3, 4'd0, 4'd14, 4'd13, 4'd5, 4'd9, 4'd11, 4'd2};
    localparam logic [3:0] SB3 [16] = '{4'd2, 4'd15, 4'd12, 4'd1, 4'd5, 4'd6, 4'd10, 4'd13,
                                        4'd14, 4'd8, 4'd3, 4'd4, 4'd0, 4'd11, 4'd9, 4'd7};
    localparam logic [3:0] SB4 [16] = '{4'd15, 4'd4, 4'd5, 4'd8, 4'd9, 4'd7, 4'd2, 4'd1,
                                        4'd10, 4'd3, 4'd0, 4'd14, 4'd6, 4'd12, 4'd13, 4'd11};

    localparam logic [127:0] K0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] S0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  ct;
    logic [127:0] key;
    logic [127:0] d_st;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  pt;
    logic [15:0]  r1_o, r2_o, r3_o, r4_o, r5_o, r6_o, r7_o, r8_o;
    logic [127:0] q_st;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign q_st = {r1_o, r2_o, r3_o, r4_o, r5_o, r6_o, r7_o, r8_o};

    hb2_decryption dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .r1        (d_st[127:112]),
        .r2        (d_st[111:96]),
        .r3        (d_st[95:80]),
        .r4        (d_st[79:64]),
        .r5        (d_st[63:48]),
        .r6        (d_st[47:32]),
        .r7        (d_st[31:16]),
        .r8        (d_st[15:0]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .r1_o      (r1_o),
        .r2_o      (r2_o),
        .r3_o      (r3_o),
        .r4_o      (r4_o),
        .r5_o      (r5_o),
        .r6_o      (r6_o),
        .r7_o      (r7_o),
        .r8_o      (r8_o)
    );

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [15:0] ffw(input logic [15:0] x);
        logic [15:0] s;
        s = {SB4[x[15:12]], SB3[x[11:8]], SB2[x[7:4]], SB1[x[3:0]]};
        return s ^ rotl(s, 6) ^ rotl(s, 10);
    endfunction

    function automatic logic [15:0] wd16(input logic [15:0] x, input logic [15:0] ka,
                                         input logic [15:0] kb, input logic [15:0] kc,
                                         input logic [15:0] kd);
        logic [15:0] v;
        v = ffw(x ^ ka);
        v = ffw(v ^ kb);
        v = ffw(v ^ kc);
        return ffw(v ^ kd);
    endfunction

    function automatic logic [15:0] w16(input logic [127:0] v, input int i);
        return v[127 - 16 * i -: 16];
    endfunction

    // Forward encryptor: returns {ct, R1'..R8'}.
    function automatic logic [143:0] enc(input logic [15:0] p, input logic [127:0] k,
                                         input logic [127:0] s);
        logic [15:0] t1, t2, t3, c, a, n1, n2, n3, n4;
        a  = w16(s, 0) + p;
        t1 = wd16(a, w16(k, 0), w16(k, 1), w16(k, 2), w16(k, 3));
        a  = w16(s, 1) + t1;
        t2 = wd16(a, w16(k, 4) ^ w16(s, 4), w16(k, 5) ^ w16(s, 5),
                  w16(k, 6) ^ w16(s, 6), w16(k, 7) ^ w16(s, 7));
        a  = w16(s, 2) + t2;
        t3 = wd16(a, w16(k, 0) ^ w16(s, 4), w16(k, 1) ^ w16(s, 5),
                  w16(k, 2) ^ w16(s, 6), w16(k, 3) ^ w16(s, 7));
        a  = w16(s, 3) + t3;
        c  = wd16(a, w16(k, 4), w16(k, 5), w16(k, 6), w16(k, 7)) + w16(s, 0);
        n1 = w16(s, 0) + t3;
        n2 = w16(s, 1) + t1;
        n3 = w16(s, 2) + t2;
        n4 = w16(s, 3) + w16(s, 0) + t3 + t1;
        return {c, n1, n2, n3, n4, w16(s, 4) ^ n1, w16(s, 5) ^ n2, w16(s, 6) ^ n3,
                w16(s, 7) ^ n4};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic [15:0] c, input logic [127:0] k,
                              input logic [127:0] s);
        int g;
        ct = c;
        key = k;
        d_st = s;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 40) begin
            tick();
            g++;
        end
        check("accept_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [15:0] p, input logic [127:0] k,
                             input logic [127:0] s, output logic [127:0] nst);
        logic [143:0] e;
        int lat;
        e = enc(p, k, s);
        start_word(e[143:128], k, s);
        wait_done(lat);
        check({tag, "_latency"}, 128'(lat), 128'd16);
        check({tag, "_pt"}, 128'(pt), 128'(p));
        check({tag, "_state"}, q_st, e[127:0]);
        tick();
        check({tag, "_exit"}, 128'(out_valid), 128'd0);
        nst = e[127:0];
    endtask

    initial begin
        logic [127:0] st;
        logic [127:0] sw;
        logic [143:0] e;
        logic [15:0]  p;
        int lat;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ct = '0;
        key = '0;
        d_st = '0;
        repeat (3) tick();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_pt", 128'(pt), 128'd0);
        check("rst_state", q_st, 128'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 128'(in_ready), 128'd1);

        out_ready = 1'b1;
        run_check("roundtrip", 16'h1234, K0, S0, st);
        check("roundtrip_in_ready", 128'(in_ready), 128'd1);

        st = S0;
        for (int i = 0; i < 8; i++) begin
            run_check("stream", 16'(i), K0, st, st);
        end
        check("stream_final_state", q_st, st);

        // Backpressure: DONE must hold for 10 cycles, ignoring an in_valid pulse.
        out_ready = 1'b0;
        e = enc(16'hBEEF, K0, S0);
        start_word(e[143:128], K0, S0);
        wait_done(lat);
        check("bp_latency", 128'(lat), 128'd16);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_pt", 128'(pt), 128'h0BEEF);
            check("bp_state", q_st, e[127:0]);
            in_valid = (i == 3);
            ct = 16'h5A5A;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_exit_valid", 128'(out_valid), 128'd0);
        check("bp_exit_ready", 128'(in_ready), 128'd1);

        // Busy-ignore: inputs disturbed at RUN cycle 5.
        e = enc(16'h1234, K0, S0);
        start_word(e[143:128], K0, S0);
        repeat (4) tick();
        ct = ~e[143:128];
        key = ~K0;
        d_st = ~S0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        check("busy_latency", 128'(lat + 5), 128'd16);
        check("busy_pt", 128'(pt), 128'h01234);
        check("busy_state", q_st, e[127:0]);
        repeat (20) tick();
        check("busy_no_second", 128'(out_valid), 128'd0);

        // Reset at RUN cycle 9: previous result is non-zero, so clearing is visible.
        e = enc(16'h4321, K0, S0);
        start_word(e[143:128], K0, S0);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_pt", 128'(pt), 128'd0);
        check("midrst_state", q_st, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        run_check("post_reset", 16'h1234, K0, S0, st);

        // Wrap-around: R1 = R4 = 0xFFFF so ct - R1 and the R4 update both wrap.
        sw = 128'hFFFF_2222_3333_FFFF_5555_6666_7777_8888;
        p = 16'h00A5;
        e = enc(p, K0, sw);
        for (int i = 0; i < 16 && e[143:128] == 16'hFFFF; i++) begin
            p = p + 16'd1;
            e = enc(p, K0, sw);
        end
        run_check("wrap", p, K0, sw, st);
        check("wrap_r4", 128'(r4_o), 128'(st[79:64]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
